zero_check_arbiter: RTL and testbench

- Shared, serialised zero-detect resource for the datapath.
- Two requesters, for example the branch-compare unit and the loop/count unit, submit a WIDTH-bit operand each.
- A round-robin arbiter grants one requester at a time. The block scans the operand CHUNK bits per cycle and returns a registered Z flag with a one-cycle ack.
- Replaces two full-width OR-trees with one CHUNK-wide tree plus a sequencer.

---
 rtl/zero_check_arbiter.sv | 155 +++++++++++++++
 tb/tb_zero_check_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zero_check_arbiter.sv
// Shared zero-detect engine: round-robin grant between two requesters, CHUNK-bit scan per cycle.
// Build option ZCHK_EARLY_EXIT_EN ends the scan on the first nonzero chunk; default is constant latency.
module zero_check_arbiter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  output logic             z0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic             z1,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  // state | meaning
  // IDLE  | waiting for a request; arbitration happens here
  // SCAN  | examining sr one chunk per cycle
  // DONE  | ack pulse to the owner, pointer handed to the other requester
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              ptr_q, ptr_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              z0_q, z0_d, z1_q, z1_d;
  logic              busy_q, busy_d;
  logic              nz;
  logic              sel1;
  logic              fin;
  logic              res;
`ifndef ZCHK_EARLY_EXIT_EN
  logic              acc_q, acc_d;
`endif

  assign nz = |sr_q[CHUNK-1:0];

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    z0_d    = z0_q;
    z1_d    = z1_q;
    sel1    = 1'b0;
    fin     = 1'b0;
    res     = 1'b0;
`ifndef ZCHK_EARLY_EXIT_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          sel1    = req1 && (!req0 || ptr_q);
          owner_d = sel1;
          sr_d    = sel1 ? data1 : data0;
          cnt_d   = '0;
`ifndef ZCHK_EARLY_EXIT_EN
          acc_d   = 1'b0;
`endif
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
`ifdef ZCHK_EARLY_EXIT_EN
        if (nz) begin
          fin = 1'b1;
          res = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          fin = 1'b1;
          res = 1'b1;
        end
`else
        // every chunk is visited; the sticky OR carries earlier chunks forward
        acc_d = acc_q | nz;
        if (cnt_q == CNT_LAST) begin
          fin = 1'b1;
          res = !(acc_q | nz);
        end
`endif
        if (fin) begin
          state_d = S_DONE;
          if (owner_q) begin
            ack1_d = 1'b1;
            z1_d   = res;
          end else begin
            ack0_d = 1'b1;
            z0_d   = res;
          end
        end else begin
          sr_d  = sr_q >> CHUNK;
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        ptr_d   = !owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      z0_q    <= 1'b0;
      z1_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifndef ZCHK_EARLY_EXIT_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      z0_q    <= z0_d;
      z1_q    <= z1_d;
      busy_q  <= busy_d;
`ifndef ZCHK_EARLY_EXIT_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign z0   = z0_q;
  assign z1   = z1_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_zero_check_arbiter.sv
// Self-checking bench for zero_check_arbiter: directed scenarios plus randomized operations
// checked against a latency/result model derived from the chunk rules.
module tb_zero_check_arbiter;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0, req1;
  logic [WIDTH-1:0] data0, data1;
  logic             ack0, ack1, z0, z1, busy;

  int checks = 0;
  int errors = 0;

  zero_check_arbiter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .data0 (data0),
    .ack0  (ack0),
    .z0    (z0),
    .req1  (req1),
    .data1 (data1),
    .ack1  (ack1),
    .z1    (z1),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // cycles from the sampling IDLE cycle to the ack cycle
  function automatic int exp_lat(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] mask;
    mask = (WIDTH'(1) << CHUNK) - 1;
`ifdef ZCHK_EARLY_EXIT_EN
    for (int j = 0; j < N; j++)
      if (((d >> (j * CHUNK)) & mask) != 0) return j + 2;
`else
    if (mask == 0) return 0;
`endif
    return N + 1;
  endfunction

  // waits for ack of requester idx, drops its req, then steps into the following IDLE cycle
  task automatic wait_ack(input int idx, output int lat, output bit other, output bit busy_ok);
    lat = -1;
    other = 1'b0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if ((idx == 0 && ack1) || (idx == 1 && ack0)) other = 1'b1;
      if ((idx == 0 && ack0) || (idx == 1 && ack1)) begin
        lat = c;
        break;
      end
    end
    if (idx == 0) req0 = 1'b0; else req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    data0 = '0; data1 = '0;
    #12;
    checks++;
    if ({ack0, ack1} !== 2'b00) begin
      errors++; $display("FAIL reset_ack: got %b expected 00", {ack0, ack1});
    end
    checks++;
    if ({z0, z1, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_z_busy: got %b expected 000", {z0, z1, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_zero();
    int lat; bit oth, bok;
    data0 = 32'h0000_0000; req0 = 1'b1;
    wait_ack(0, lat, oth, bok);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL zero_lat: got %0d expected 5", lat); end
    checks++;
    if (z0 !== 1'b1) begin errors++; $display("FAIL zero_z0: got %b expected 1", z0); end
    checks++;
    if (oth !== 1'b0 || bok !== 1'b1) begin
      errors++; $display("FAIL zero_ack1_busy: ack1seen=%b busy_ok=%b expected 0/1", oth, bok);
    end
  endtask

  task automatic test_chunk1();
    int lat; bit oth, bok;
    data1 = 32'h0000_0100; req1 = 1'b1;
    wait_ack(1, lat, oth, bok);
    checks++;
    if (lat !== exp_lat(32'h0000_0100)) begin
      errors++; $display("FAIL chunk1_lat: got %0d expected %0d", lat, exp_lat(32'h0000_0100));
    end
    checks++;
    if (z1 !== 1'b0 || z0 !== 1'b1) begin
      errors++; $display("FAIL chunk1_z: got z1=%b z0=%b expected z1=0 z0=1", z1, z0);
    end
  endtask

  task automatic test_early_exit();
    int lat; bit oth, bok;
    data0 = 32'h0000_0001; req0 = 1'b1;
    wait_ack(0, lat, oth, bok);
    checks++;
    if (lat !== exp_lat(32'h0000_0001) || z0 !== 1'b0) begin
      errors++; $display("FAIL early_lsb: got lat=%0d z0=%b expected lat=%0d z0=0", lat, z0, exp_lat(32'h0000_0001));
    end
    data0 = 32'h8000_0000; req0 = 1'b1;
    wait_ack(0, lat, oth, bok);
    checks++;
    if (lat !== 5 || z0 !== 1'b0) begin
      errors++; $display("FAIL early_msb: got lat=%0d z0=%b expected lat=5 z0=0", lat, z0);
    end
  endtask

  task automatic test_tie();
    int lat; bit oth, bok;
    do_reset();
    data0 = 32'h0; data1 = 32'hFFFF_FFFF;
    req0 = 1'b1; req1 = 1'b1;
    wait_ack(0, lat, oth, bok);
    checks++;
    if (lat !== 5 || z0 !== 1'b1 || oth !== 1'b0) begin
      errors++; $display("FAIL tie_first: got lat=%0d z0=%b ack1seen=%b expected 5/1/0", lat, z0, oth);
    end
    wait_ack(1, lat, oth, bok);
    checks++;
    if (lat !== exp_lat(32'hFFFF_FFFF) || z1 !== 1'b0 || oth !== 1'b0) begin
      errors++; $display("FAIL tie_second: got lat=%0d z1=%b ack0seen=%b expected %0d/0/0", lat, z1, oth, exp_lat(32'hFFFF_FFFF));
    end
    req0 = 1'b1; req1 = 1'b1;
    wait_ack(0, lat, oth, bok);
    checks++;
    if (lat !== 5 || oth !== 1'b0) begin
      errors++; $display("FAIL tie_rr0: got lat=%0d ack1seen=%b expected 5/0", lat, oth);
    end
    req0 = 1'b1;
    wait_ack(1, lat, oth, bok);
    checks++;
    if (lat !== exp_lat(32'hFFFF_FFFF) || oth !== 1'b0) begin
      errors++; $display("FAIL tie_rr1: got lat=%0d ack0seen=%b expected %0d/0", lat, oth, exp_lat(32'hFFFF_FFFF));
    end
    wait_ack(0, lat, oth, bok);
    checks++;
    if (lat !== 5 || z0 !== 1'b1) begin
      errors++; $display("FAIL tie_tail: got lat=%0d z0=%b expected 5/1", lat, z0);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat, acks; bit oth, bok;
    data0 = 32'h0; req0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ack0 !== 1'b0 || z0 !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got ack0=%b z0=%b busy=%b expected 0/0/0", ack0, z0, busy);
    end
    req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack0 || ack1 || busy) acks++;
    end
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL midreset_no_ack: got %0d active cycles expected 0", acks); end
    data0 = 32'h0000_0005; data1 = 32'h0;
    req0 = 1'b1; req1 = 1'b1;
    wait_ack(0, lat, oth, bok);
    checks++;
    if (lat !== exp_lat(32'h0000_0005) || oth !== 1'b0 || z0 !== 1'b0) begin
      errors++; $display("FAIL midreset_tie: got lat=%0d ack1seen=%b z0=%b expected %0d/0/0", lat, oth, z0, exp_lat(32'h0000_0005));
    end
    wait_ack(1, lat, oth, bok);
  endtask

  task automatic test_wait_during_scan();
    int lat; bit oth, bok;
    data0 = 32'h0; req0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    data1 = 32'h0000_00FF; req1 = 1'b1;
    wait_ack(0, lat, oth, bok);
    // two of the five cycles were already spent before wait_ack started counting
    checks++;
    if (lat !== 3 || oth !== 1'b0 || z0 !== 1'b1) begin
      errors++; $display("FAIL pend_first: got lat=%0d ack1seen=%b z0=%b expected 3/0/1", lat, oth, z0);
    end
    checks++;
    if (busy !== 1'b0 || ack1 !== 1'b0) begin
      errors++; $display("FAIL pend_gap: got busy=%b ack1=%b expected 0/0", busy, ack1);
    end
    wait_ack(1, lat, oth, bok);
    checks++;
    if (lat !== exp_lat(32'h0000_00FF) || z1 !== 1'b0 || z0 !== 1'b1) begin
      errors++; $display("FAIL pend_second: got lat=%0d z1=%b z0=%b expected %0d/0/1", lat, z1, z0, exp_lat(32'h0000_00FF));
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_data();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return WIDTH'(1) << $urandom_range(0, WIDTH - 1);
      2:       return WIDTH'($urandom);
      default: return WIDTH'($urandom) & 32'hFF00_0000;
    endcase
  endfunction

  task automatic test_random();
    int lat, sel, first, second;
    bit oth, bok, ptr;
    bit mz [2];
    logic [WIDTH-1:0] d [2];
    do_reset();
    ptr = 1'b0; mz[0] = 1'b0; mz[1] = 1'b0;
    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(1, 3);
      d[0] = rand_data(); d[1] = rand_data();
      data0 = d[0]; data1 = d[1];
      req0 = sel[0]; req1 = sel[1];
      first = (sel == 3) ? int'(ptr) : ((sel == 1) ? 0 : 1);
      second = 1 - first;
      for (int k = 0; k < ((sel == 3) ? 2 : 1); k++) begin
        int w;
        w = (k == 0) ? first : second;
        wait_ack(w, lat, oth, bok);
        mz[w] = (d[w] == '0);
        ptr = (w == 0);
        checks++;
        if (lat !== exp_lat(d[w]) || oth !== 1'b0 || bok !== 1'b1) begin
          errors++; $display("FAIL rand_timing it=%0d req%0d: got lat=%0d other=%b busy_ok=%b expected lat=%0d", it, w, lat, oth, bok, exp_lat(d[w]));
        end
        checks++;
        if (z0 !== mz[0] || z1 !== mz[1]) begin
          errors++; $display("FAIL rand_z it=%0d: got z0=%b z1=%b expected z0=%b z1=%b", it, z0, z1, mz[0], mz[1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_chunk1();
    test_early_exit();
    test_tie();
    test_reset_mid_scan();
    test_wait_during_scan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
